// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit order, off pattern, hex font.
package seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high internal encoding; pin polarity is applied only at the output register.
  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] w_font;
    case (nib)
      4'h0:    w_font = 7'h3F;
      4'h1:    w_font = 7'h06;
      4'h2:    w_font = 7'h5B;
      4'h3:    w_font = 7'h4F;
      4'h4:    w_font = 7'h66;
      4'h5:    w_font = 7'h6D;
      4'h6:    w_font = 7'h7D;
      4'h7:    w_font = 7'h07;
      4'h8:    w_font = 7'h7F;
      4'h9:    w_font = 7'h6F;
      4'hA:    w_font = 7'h77;
      4'hB:    w_font = 7'h7C;
      4'hC:    w_font = 7'h39;
      4'hD:    w_font = 7'h5E;
      4'hE:    w_font = 7'h79;
      default: w_font = 7'h71;
    endcase
    return w_font;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot prescaler and scan index; digit_tick marks the cycle whose edge advances the index.
module seg_scan_timer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned PRESC_W    = 16,
  parameter int unsigned IDX_W      = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic [PRESC_W-1:0] o_presc,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_tick
);

  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IdxLast   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PrescLast) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IdxLast) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign o_presc = r_presc;
  assign o_idx   = r_idx;
  assign o_tick  = i_enable && !i_rst && (r_presc == PrescLast);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver: data latch, digit mux with leading-zero suppression,
// anti-ghost blanking and a polarity-aware registered pin stage.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lz_blank_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_tick
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0]            SegInv = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnInv  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic [PrescW-1:0]     w_presc;
  logic [IdxW-1:0]       w_idx;
  logic                  w_blank;
  logic                  w_run_zero;
  logic                  w_dark;
  logic                  w_dp;
  logic [3:0]            w_nibble;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .PRESC_W    (PrescW),
    .IDX_W      (IdxW)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (enable),
    .o_presc  (w_presc),
    .o_idx    (w_idx),
    .o_tick   (digit_tick)
  );

  assign w_blank = (w_presc < PrescW'(BLANK_CYCLES));

  // Walk from the top digit down so w_run_zero means "this nibble and all above are zero".
  always_comb begin
    w_run_zero = 1'b1;
    w_dark     = 1'b0;
    w_dp       = 1'b0;
    w_nibble   = 4'h0;
    w_an_next  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run_zero   = w_run_zero & (r_value[4*k +: 4] == 4'h0);
      w_an_next[k] = !w_blank && (w_idx == IdxW'(k));
      if (w_idx == IdxW'(k)) begin
        w_nibble = r_value[4*k +: 4];
        w_dp     = r_dp[k];
        w_dark   = lz_blank_en && w_run_zero && (k != 0);
      end
    end
    w_seg_next         = {1'b0, w_dark ? 7'h00 : hex2seg(w_nibble)};
    w_seg_next[SEG_DP] = w_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_seg   <= SEG_OFF ^ SegInv;
      r_an    <= AnInv;
    end else begin
      if (load) begin
        r_value <= value_i;
        r_dp    <= dp_i;
      end
      if (!enable) begin
        r_seg <= SEG_OFF ^ SegInv;
        r_an  <= AnInv;
      end else begin
        r_seg <= w_seg_next ^ SegInv;
        r_an  <= w_an_next ^ AnInv;
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
